// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: requester indices, arbiter
// state encoding and the lock-counter helper.
package dmem_arbiter_pkg;

    localparam int REQ_CPU      = 0;
    localparam int REQ_LDR      = 1;
    localparam int MAX_LOCK_DEF = 4;
    localparam int LCNT_W       = 4;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_st_e;

    // Lock counter saturates at all-ones instead of wrapping.
    function automatic logic [LCNT_W-1:0] lcnt_inc(input logic [LCNT_W-1:0] c);
        return (c == {LCNT_W{1'b1}}) ? c : c + {{(LCNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way priority pick: a lone request wins outright, a tie goes to prio_i.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = prio_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared single-port data memory, with bounded
// lock bursts and a registered, one-cycle read/error response.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF,
    parameter int AW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wd0,
    input  logic [31:0]   wd1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [31:0]   rdata,
    output logic          err0,
    output logic          err1,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd
);

    localparam logic [LCNT_W-1:0] MAX_LOCK_C = LCNT_W'(MAX_LOCK);

    arb_st_e           st_q, st_d;
    logic              prio_q, prio_d;
    logic              owner_q, owner_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;

    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [1:0]        req_v;
    logic [1:0]        pick_req;
    logic              pick_prio;
    logic [1:0]        pick_gnt;

    logic              gnt_any;
    logic              gidx;
    logic              g_we;
    logic              g_lock;
    logic [AW-1:0]     g_addr;
    logic [31:0]       g_wd;
    logic              g_mis;

    assign req_v[REQ_CPU] = req0;
    assign req_v[REQ_LDR] = req1;

    // While locked the owner keeps the tie-break unless its budget is spent,
    // in which case a waiting peer wins; an absent owner lets the peer in.
    always_comb begin
        pick_req  = reset ? 2'b00 : req_v;
        pick_prio = prio_q;
        if (st_q == ARB_LOCKED) begin
            pick_prio = (lcnt_q >= MAX_LOCK_C) ? ~owner_q : owner_q;
        end
    end

    rr_pick2 u_pick (
        .req_i  (pick_req),
        .prio_i (pick_prio),
        .gnt_o  (pick_gnt)
    );

    assign gnt0    = pick_gnt[REQ_CPU];
    assign gnt1    = pick_gnt[REQ_LDR];
    assign gnt_any = |pick_gnt;
    assign gidx    = pick_gnt[REQ_LDR];

    assign g_we   = gidx ? we1   : we0;
    assign g_lock = gidx ? lock1 : lock0;
    assign g_addr = gidx ? addr1 : addr0;
    assign g_wd   = gidx ? wd1   : wd0;
    assign g_mis  = |g_addr[1:0];

    // Misaligned accesses are granted but never reach the memory.
    assign mem_we = gnt_any & g_we & ~g_mis;
    assign mem_a  = gnt_any ? g_addr : '0;
    assign mem_wd = gnt_any ? g_wd   : '0;

    always_comb begin
        st_d    = st_q;
        owner_d = owner_q;
        lcnt_d  = lcnt_q;
        prio_d  = prio_q;
        if (gnt_any) begin
            prio_d = ~gidx;
            if (st_q == ARB_LOCKED && gidx == owner_q && g_lock) begin
                lcnt_d = lcnt_inc(lcnt_q);
            end else if (g_lock) begin
                st_d    = ARB_LOCKED;
                owner_d = gidx;
                lcnt_d  = {{(LCNT_W-1){1'b0}}, 1'b1};
            end else begin
                st_d   = ARB_FREE;
                lcnt_d = '0;
            end
        end else begin
            st_d   = ARB_FREE;
            lcnt_d = '0;
        end
    end

    always_comb begin
        rvalid_d = 2'b00;
        err_d    = 2'b00;
        rdata_d  = rdata_q;
        if (gnt_any) begin
            if (g_mis) begin
                rvalid_d = pick_gnt;
                err_d    = pick_gnt;
                rdata_d  = '0;
            end else if (!g_we) begin
                rvalid_d = pick_gnt;
                rdata_d  = mem_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q     <= ARB_FREE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            lcnt_q   <= '0;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            rdata_q  <= '0;
        end else begin
            st_q     <= st_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            lcnt_q   <= lcnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid0 = rvalid_q[REQ_CPU];
    assign rvalid1 = rvalid_q[REQ_LDR];
    assign err0    = err_q[REQ_CPU];
    assign err1    = err_q[REQ_LDR];
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural arbiter and
// memory model; responses are checked by an independent monitor process.
module tb_dmem_arbiter;

    localparam int AW   = 32;
    localparam int MAXL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   wd0, wd1;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0]   rdata;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_LOCK(MAXL), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .lock0   (lock0),
        .lock1   (lock1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wd0     (wd0),
        .wd1     (wd1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata   (rdata),
        .err0    (err0),
        .err1    (err1),
        .mem_we  (mem_we),
        .mem_a   (mem_a),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    // Memory the DUT talks to: asynchronous read, synchronous write.
    logic [31:0] mem [0:63];
    bit          filled = 1'b0;
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            filled <= 1'b1;
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic [31:0] smem [0:63];
    int m_prio, m_locked, m_owner, m_cnt;
    int cyc = 0;
    int exp_g, act_g;

    typedef struct {
        int          who;
        bit          err;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    task automatic step(input bit rst, input bit r0, input bit r1, input bit w0, input bit w1,
                        input bit l0, input bit l1, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        int g;
        int oth;
        bit rq[2];
        bit lk[2];
        bit gw, mis;
        logic [31:0] ga, gd;
        exp_t e;
        @(negedge clk);
        reset = rst; req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        lock0 = l0; lock1 = l1; addr0 = a0; addr1 = a1; wd0 = d0; wd1 = d1;
        #1;
        rq[0] = r0; rq[1] = r1; lk[0] = l0; lk[1] = l1;
        g = -1;
        if (!rst) begin
            if (m_locked != 0 && rq[m_owner]) begin
                oth = 1 - m_owner;
                g = (m_cnt >= MAXL && rq[oth]) ? oth : m_owner;
            end else if (rq[0] && rq[1]) begin
                g = m_prio;
            end else if (rq[0]) begin
                g = 0;
            end else if (rq[1]) begin
                g = 1;
            end
        end
        exp_g = g;
        act_g = (gnt0 && gnt1) ? 2 : gnt1 ? 1 : gnt0 ? 0 : -1;
        chk("gnt0", 32'(gnt0), 32'(g == 0));
        chk("gnt1", 32'(gnt1), 32'(g == 1));
        if (g >= 0) begin
            ga  = (g == 1) ? a1 : a0;
            gd  = (g == 1) ? d1 : d0;
            gw  = (g == 1) ? w1 : w0;
            mis = (ga[1:0] != 2'b00);
            chk("mem_we", 32'(mem_we), 32'(gw && !mis));
            chk("mem_a", mem_a, ga);
            if (gw && !mis) chk("mem_wd", mem_wd, gd);
            e.who = g;
            e.due = cyc + 1;
            if (mis) begin
                e.err = 1'b1; e.data = 32'h0; q.push_back(e);
            end else if (!gw) begin
                e.err = 1'b0; e.data = smem[ga[7:2]]; q.push_back(e);
            end else begin
                smem[ga[7:2]] = gd;
            end
            m_prio = 1 - g;
            if (m_locked != 0 && g == m_owner && lk[g]) begin
                m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            end else if (lk[g]) begin
                m_locked = 1; m_owner = g; m_cnt = 1;
            end else begin
                m_locked = 0; m_cnt = 0;
            end
        end else begin
            chk("mem_we_idle", 32'(mem_we), 32'h0);
            chk("mem_a_idle", mem_a, 32'h0);
            m_locked = 0; m_cnt = 0;
        end
        if (rst) begin
            m_prio = 0; m_locked = 0; m_owner = 0; m_cnt = 0;
        end
    endtask

    // Response monitor: pops the scoreboard whenever a response appears.
    logic [31:0] held = 32'h0;
    always begin : monitor
        bit   rst_s;
        exp_t e;
        @(posedge clk);
        rst_s = reset;
        cyc++;
        #1;
        if (rst_s) held = 32'h0;
        if (rvalid0 || rvalid1) begin
            chk("rvalid_excl", 32'(rvalid0 & rvalid1), 32'h0);
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rvalid_unexpected actual=%b%b expected=none at %0t", rvalid1, rvalid0, $time);
            end else begin
                e = q.pop_front();
                chk("rvalid_who", 32'(rvalid1), 32'(e.who));
                chk("err", 32'(rvalid1 ? err1 : err0), 32'(e.err));
                chk("err_other", 32'(rvalid1 ? err0 : err1), 32'h0);
                chk("rdata", rdata, e.data);
                chk("rvalid_latency", 32'(cyc), 32'(e.due));
                held = e.data;
            end
        end else begin
            chk("err_idle", 32'(err0 | err1), 32'h0);
            chk("rdata_hold", rdata, held);
            if (q.size() > 0 && q[0].due <= cyc) begin
                checks++; errors++;
                $display("FAIL rvalid_missing actual=none expected=req%0d at %0t", q[0].who, $time);
                void'(q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] raddr();
        logic [31:0] a;
        a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
        if ($urandom % 8 == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin : driver
        int lock_seq[9];
        bit p0, p1, r0, r1, w0, w1, l0, l1;
        logic [31:0] a0, a1, d0, d1;
        lock_seq = '{0, 0, 0, 0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 64; i++) smem[i] = init_val(i);
        m_prio = 0; m_locked = 0; m_owner = 0; m_cnt = 0;
        reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;

        step(1, 1, 1, 0, 0, 0, 0, 32'h0, 32'h4, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Single read of word 4.
        step(0, 1, 0, 0, 0, 0, 0, 32'h10, 32'h0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Both requesting reads: alternation.
        for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 0, 0, 0, 32'h0, 32'h4, 0, 0);

        // Loader write then CPU read-back.
        step(0, 0, 1, 0, 1, 0, 0, 32'h0, 32'h20, 0, 32'h12345678);
        step(0, 1, 0, 0, 0, 0, 0, 32'h20, 32'h0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Bounded lock with forced hand-over.
        step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            step(0, 1, 1, 0, 0, (k < 5), 0, 32'h8, 32'hC, 0, 0);
            chk("lock_seq", 32'(act_g), 32'(lock_seq[k]));
        end

        // Misaligned loader read.
        step(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h22, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Reset in the middle of a locked burst.
        step(0, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0, 0, 0);
        step(0, 1, 1, 0, 0, 1, 0, 32'h4, 32'h8, 0, 0);
        step(1, 1, 1, 0, 1, 1, 0, 32'h4, 32'h8, 0, 32'hFFFF0000);
        step(0, 1, 1, 0, 0, 0, 0, 32'h4, 32'h8, 0, 0);
        chk("post_reset_first", 32'(act_g), 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Random traffic, requests held until granted.
        p0 = 0; p1 = 0;
        r0 = 0; r1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int k = 0; k < 600; k++) begin
            if (!p0) begin
                r0 = ($urandom % 3) != 0; w0 = ($urandom % 3) == 0; a0 = raddr(); d0 = $urandom;
            end
            if (!p1) begin
                r1 = ($urandom % 3) != 0; w1 = ($urandom % 3) == 0; a1 = raddr(); d1 = $urandom;
            end
            l0 = ($urandom % 4) != 0;
            l1 = ($urandom % 3) == 0;
            step(($urandom % 80) == 0, r0, r1, w0, w1, l0, l1, a0, a1, d0, d1);
            chk("gnt_excl", 32'(act_g == 2), 32'h0);
            p0 = r0 && (exp_g != 0);
            p1 = r1 && (exp_g != 1);
        end

        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-port data memory (asynchronous read, synchronous write, word-addressed) between the CPU load/store path (requester 0) and the program/debug loader (requester 1). Each cycle it grants at most one requester with round-robin fairness, drives the memory port, and returns registered read data with a one-cycle valid pulse. A bounded lock lets one requester hold the memory for short bursts without starving the other.

## Interface
Parameters:
- MAX_LOCK, 4, max consecutive locked grants before a forced hand-over (1..15)
- AW, 32, address width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  request, level, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  request to keep the grant next cycle
- addr0 / addr1  in  AW  byte address
- wd0 / wd1  in  32  write data
- gnt0 / gnt1  out  1  combinational grant, same cycle as req
- rvalid0 / rvalid1  out  1  registered; read data or error valid
- rdata  out  32  registered read data, shared by both requesters
- err0 / err1  out  1  registered; misaligned access rejected, valid with rvalid
- mem_we  out  1  memory write enable
- mem_a  out  AW  memory address
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data (asynchronous)

## Operation
- State: prio (1 bit, requester that wins a tie), st ∈ {FREE, LOCKED}, owner (1 bit), lcnt (4 bits).
- FREE: only one req → grant it; both → grant prio; then prio ← ~granted.
- Granted requester with lock=1 and req=1 → st ← LOCKED, owner ← granted, lcnt ← 1.
- LOCKED: owner granted if req_owner=1, regardless of the other request. lcnt increments per locked grant. Return to FREE when owner drops req or lock, or when lcnt = MAX_LOCK and the other requester is requesting; in the forced case the other requester is granted that cycle.
- LOCKED with owner req=0: st ← FREE immediately; the other requester may be granted in the same cycle.
- Granted access drives mem_a = addr, mem_wd = wd, mem_we = we. With no grant, mem_we=0, mem_a=0, mem_wd=0.
- Misaligned access (addr[1:0] ≠ 0): granted but memory not touched (mem_we=0). Next cycle rvalid=1, err=1, rdata=0. Applies to reads and writes.
- Aligned write: no rvalid, no err.
- Aligned read: mem_rd captured into rdata at the clock edge; rvalid=1 for the granted requester next cycle.
- rdata holds its last value when rvalid is low.
- gnt0 and gnt1 are never both high.

## Timing
- Reset values: gnt0/1=0 while reset high; rvalid0/1=0, err0/1=0, rdata=0, mem_we=0. Internal: prio=0 (requester 0 wins the first tie), st=FREE, lcnt=0.
- Grant latency 0 cycles (Mealy on req). Read latency 1 cycle (rvalid in cycle N+1 for grant in N). Write commits at the edge ending cycle N.
- Throughput: one access per cycle. Back-to-back reads from one requester give rvalid on consecutive cycles.
- Reset mid-burst: lock is abandoned, no rvalid after reset release for accesses granted in the reset cycle, and memory is not written during reset.
- Simultaneous lock by both in FREE: only the granted requester's lock is honoured.
- lcnt saturates; it never wraps.

## Structure
- Shared package: requester index constants REQ_CPU=0, REQ_LDR=1; state encoding ARB_FREE/ARB_LOCKED; MAX_LOCK default.
- One combinational sub-module, rr_pick2: inputs (req[1:0], prio) → one-hot grant. Used in the FREE path and for the forced hand-over.
- Top holds the state, lcnt, response registers and the memory mux.

## Test plan
- Reset then req0 only, read of addr 0x10 with mem word 4 = 0xDEADBEEF → gnt0 same cycle, next cycle rvalid0=1, rdata=0xDEADBEEF, err0=0.
- req0 and req1 both held for 4 cycles (reads) → grants 0,1,0,1; each rvalid matches the prior cycle's grant.
- req1 write 0x12345678 to 0x20, then req0 read of 0x20 → mem_we only in the write cycle; the read returns 0x12345678.
- lock0=1, req0 held, req1 held, MAX_LOCK=4 → gnt0 for 4 cycles, gnt1 in cycle 5, then alternation.
- req1 read of addr 0x22 → gnt1, mem_we=0; next cycle rvalid1=1, err1=1, rdata=0.
- Reset asserted during a locked burst → gnt0/1=0, no rvalid the cycle after; after release both requesting → requester 0 granted first.
